cache_memory: RTL and testbench



---
 rtl/cache_pkg.sv | 55 +++++
 rtl/cache_memory.sv | 69 ++++++
 tb/tb_cache_memory.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/cache_pkg.sv
// Shared geometry, line field positions and word-select helpers for the data cache.
package cache_pkg;

  localparam int BLOCK_SIZE = 128;
  localparam int WORD_W     = 32;
  localparam int TAG_W      = 24;
  localparam int INDEX_W    = 6;
  localparam int OFFSET_W   = 2;
  localparam int NUM_LINES  = 64;
  localparam int LINE_W     = 154;

  localparam int VALID_BIT = 0;
  localparam int DIRTY_BIT = 1;
  localparam int TAG_LSB   = 2;
  localparam int DATA_LSB  = 26;

  // Packed view of one line; valid sits at bit 0, data occupies the top bits.
  typedef struct packed {
    logic [BLOCK_SIZE-1:0] data;
    logic [TAG_W-1:0]      tag;
    logic                  dirty;
    logic                  valid;
  } line_t;

  // Pick word 'offset' out of a block; word 0 is the least-significant word.
  function automatic logic [WORD_W-1:0] get_word(input logic [BLOCK_SIZE-1:0] block,
                                                 input logic [OFFSET_W-1:0]   offset);
    logic [WORD_W-1:0] word;
    case (offset)
      2'd0:    word = block[31:0];
      2'd1:    word = block[63:32];
      2'd2:    word = block[95:64];
      2'd3:    word = block[127:96];
      default: word = 32'h0000_0000;
    endcase
    return word;
  endfunction

  // Return 'block' with word 'offset' replaced by 'word'; other words untouched.
  function automatic logic [BLOCK_SIZE-1:0] set_word(input logic [BLOCK_SIZE-1:0] block,
                                                     input logic [OFFSET_W-1:0]   offset,
                                                     input logic [WORD_W-1:0]     word);
    logic [BLOCK_SIZE-1:0] result;
    result = block;
    case (offset)
      2'd0:    result[31:0]   = word;
      2'd1:    result[63:32]  = word;
      2'd2:    result[95:64]  = word;
      2'd3:    result[127:96] = word;
      default: result = block;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/cache_memory.sv
// Direct-mapped data-cache storage: 64 lines of {data, tag, dirty, valid}.
// Tag compare and line readout are combinational; reads register one word.
module cache_memory
  import cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TAG_W-1:0]      tag,
  input  logic [INDEX_W-1:0]    index,
  input  logic [OFFSET_W-1:0]   blk_offset,
  input  logic                  req_type,
  input  logic                  read_en_cache,
  input  logic                  write_en_cache,
  input  logic                  refill,
  input  logic [BLOCK_SIZE-1:0] data_in_mem,
  input  logic [WORD_W-1:0]     data_in,
  output logic [BLOCK_SIZE-1:0] dirty_block_out,
  output logic                  hit,
  output logic [WORD_W-1:0]     data_out,
  output logic                  dirty_bit
);

  logic [LINE_W-1:0]     cache [NUM_LINES];
  logic [LINE_W-1:0]     line_s;
  logic [BLOCK_SIZE-1:0] block_s;
  logic [WORD_W-1:0]     word_s;
  logic                  unused_req_type;

  // req_type is informational; the enables alone steer behaviour.
  assign unused_req_type = req_type;

  assign line_s          = cache[index];
  assign block_s         = line_s[DATA_LSB +: BLOCK_SIZE];
  assign hit             = line_s[VALID_BIT] && (line_s[TAG_LSB +: TAG_W] == tag);
  assign dirty_bit       = line_s[DIRTY_BIT];
  assign dirty_block_out = block_s;

  // Word-select mux feeding the read register.
  always_comb begin
    word_s = get_word(block_s, blk_offset);
  end

  // Registered read word: loads on a read hit, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= 32'h0000_0000;
    end else if (read_en_cache && hit) begin
      data_out <= word_s;
    end else begin
      data_out <= data_out;
    end
  end

  // Line array update: reset invalidates everything, refill beats word write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        cache[i][VALID_BIT] <= 1'b0;
        cache[i][DIRTY_BIT] <= 1'b0;
      end
    end else if (write_en_cache && refill) begin
      cache[index] <= {data_in_mem, tag, 1'b0, 1'b1};
    end else if (write_en_cache && hit) begin
      cache[index][DATA_LSB +: BLOCK_SIZE] <= set_word(block_s, blk_offset, data_in);
      cache[index][DIRTY_BIT]              <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_memory.sv
// Directed self-checking bench for cache_memory with backdoor line preloads.
module tb_cache_memory;

  logic         clk;
  logic         rst;
  logic [23:0]  tag;
  logic [5:0]   index;
  logic [1:0]   blk_offset;
  logic         req_type;
  logic         read_en_cache;
  logic         write_en_cache;
  logic         refill;
  logic [127:0] data_in_mem;
  logic [31:0]  data_in;
  logic [127:0] dirty_block_out;
  logic         hit;
  logic [31:0]  data_out;
  logic         dirty_bit;

  int checks = 0;
  int errors = 0;

  cache_memory dut (
    .clk             (clk),
    .rst             (rst),
    .tag             (tag),
    .index           (index),
    .blk_offset      (blk_offset),
    .req_type        (req_type),
    .read_en_cache   (read_en_cache),
    .write_en_cache  (write_en_cache),
    .refill          (refill),
    .data_in_mem     (data_in_mem),
    .data_in         (data_in),
    .dirty_block_out (dirty_block_out),
    .hit             (hit),
    .data_out        (data_out),
    .dirty_bit       (dirty_bit)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  // Advance one edge and settle 1 ns past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    read_en_cache  = 1'b0;
    write_en_cache = 1'b0;
    refill         = 1'b0;
    req_type       = 1'b0;
  endtask

  // Backdoor load of one line as {data, tag, dirty, valid}.
  task automatic load_line(input int idx, input logic [127:0] d, input logic [23:0] t,
                           input logic dty, input logic vld);
    dut.cache[idx] = {d, t, dty, vld};
  endtask

  localparam logic [127:0] D0 = 128'h12345678_22222222_11111111_00000000;
  localparam logic [127:0] D1 = 128'hDDDD0003_DDDD0002_DDDD0001_DDDD0000;
  localparam logic [127:0] R2 = 128'hCAFEBABE_F0F0AAAA_1C78F0F0_F0F0F0F0;
  localparam logic [127:0] D3 = 128'h33333333_DEADBEEF_01234567_89ABCDEF;
  localparam logic [127:0] D4 = 128'h44444444_44440002_44440001_44440000;
  localparam logic [127:0] R4 = 128'hA0A0A0A3_A0A0A0A2_A0A0A0A1_A0A0A0A0;
  localparam logic [127:0] R7 = 128'h77777773_77777772_77777771_77777770;

  initial begin
    idle();
    rst = 1'b1; tag = 24'h000000; index = 6'd0; blk_offset = 2'd0;
    data_in_mem = 128'h0; data_in = 32'h0;
    tick(); tick();
    rst = 1'b0;
    #1;

    // Compulsory misses after reset.
    check("reset_data_out", 128'(data_out), 128'h0);
    for (int i = 0; i < 64; i++) begin
      index = 6'(i);
      #1;
      check("reset_hit", 128'(hit), 128'h0);
      check("reset_dirty", 128'(dirty_bit), 128'h0);
    end

    // Refill index 7 after reset.
    index = 6'd7; tag = 24'h111111; data_in_mem = R7;
    write_en_cache = 1'b1; refill = 1'b1;
    tick(); idle(); #1;
    check("refill7_hit", 128'(hit), 128'h1);
    check("refill7_dirty", 128'(dirty_bit), 128'h0);
    check("refill7_block", dirty_block_out, R7);

    // Read hit on line 0, word 3.
    load_line(0, D0, 24'hABCDE0, 1'b0, 1'b1);
    index = 6'd0; tag = 24'hABCDE0; blk_offset = 2'd3; read_en_cache = 1'b1;
    #1;
    check("rd0_hit", 128'(hit), 128'h1);
    check("rd0_dirty", 128'(dirty_bit), 128'h0);
    tick(); idle();
    check("rd0_data", 128'(data_out), 128'h12345678);

    // Read miss on line 0 holds data_out.
    tag = 24'hABCDE1; blk_offset = 2'd1; read_en_cache = 1'b1;
    #1;
    check("rdmiss_hit", 128'(hit), 128'h0);
    tick(); idle();
    check("rdmiss_hold", 128'(data_out), 128'h12345678);

    // Write hit on line 1, word 3.
    load_line(1, D1, 24'h000ABC, 1'b0, 1'b1);
    index = 6'd1; tag = 24'h000ABC; blk_offset = 2'd3; data_in = 32'hCAFEBABE;
    write_en_cache = 1'b1; req_type = 1'b1;
    #1;
    check("wr1_hit_before", 128'(hit), 128'h1);
    tick(); idle(); #1;
    check("wr1_hit", 128'(hit), 128'h1);
    check("wr1_dirty", 128'(dirty_bit), 128'h1);
    check("wr1_block", dirty_block_out, {32'hCAFEBABE, D1[95:0]});

    // Same-cycle read and write: read returns the pre-write word.
    blk_offset = 2'd3; data_in = 32'h0BADF00D;
    read_en_cache = 1'b1; write_en_cache = 1'b1;
    tick(); idle();
    check("rdwr_old", 128'(data_out), 128'hCAFEBABE);
    read_en_cache = 1'b1;
    tick(); idle();
    check("rdwr_new", 128'(data_out), 128'h0BADF00D);

    // Clean miss on line 2, then refill.
    load_line(2, D3, 24'h222222, 1'b0, 1'b1);
    index = 6'd2; tag = 24'h333333; blk_offset = 2'd0; read_en_cache = 1'b1;
    #1;
    check("miss2_hit", 128'(hit), 128'h0);
    check("miss2_dirty", 128'(dirty_bit), 128'h0);
    tick(); idle();
    check("miss2_hold", 128'(data_out), 128'h0BADF00D);
    data_in_mem = R2; data_in = 32'hFFFFFFFF; write_en_cache = 1'b1; refill = 1'b1;
    tick(); idle(); #1;
    check("refill2_hit", 128'(hit), 128'h1);
    check("refill2_dirty", 128'(dirty_bit), 128'h0);
    check("refill2_block", dirty_block_out, R2);
    tag = 24'h222222; #1;
    check("refill2_oldtag", 128'(hit), 128'h0);

    // Dirty miss on line 3 exposes the victim block.
    load_line(3, D3, 24'h444444, 1'b1, 1'b1);
    index = 6'd3; tag = 24'h555555;
    #1;
    check("dmiss3_hit", 128'(hit), 128'h0);
    check("dmiss3_dirty", 128'(dirty_bit), 128'h1);
    check("dmiss3_block", dirty_block_out, D3);

    // Write miss without refill leaves line 4 alone; then allocate and write.
    load_line(4, D4, 24'h666666, 1'b0, 1'b1);
    index = 6'd4; tag = 24'h777777; blk_offset = 2'd3; data_in = 32'h4AFEBABE;
    write_en_cache = 1'b1;
    tick(); idle(); #1;
    check("wmiss4_hit", 128'(hit), 128'h0);
    tag = 24'h666666; #1;
    check("wmiss4_block", dirty_block_out, D4);
    check("wmiss4_dirty", 128'(dirty_bit), 128'h0);
    tag = 24'h777777; data_in_mem = R4; write_en_cache = 1'b1; refill = 1'b1;
    tick(); idle();
    write_en_cache = 1'b1;
    tick(); idle(); #1;
    check("alloc4_hit", 128'(hit), 128'h1);
    check("alloc4_dirty", 128'(dirty_bit), 128'h1);
    check("alloc4_block", dirty_block_out, {32'h4AFEBABE, R4[95:0]});

    // Reset wins over a refill in the same cycle.
    rst = 1'b1; index = 6'd5; tag = 24'h555AAA; data_in_mem = R7;
    write_en_cache = 1'b1; refill = 1'b1;
    tick(); idle(); rst = 1'b0; #1;
    check("rstwin_hit5", 128'(hit), 128'h0);
    check("rstwin_data_out", 128'(data_out), 128'h0);
    index = 6'd1; tag = 24'h000ABC; #1;
    check("rstwin_hit1", 128'(hit), 128'h0);
    check("rstwin_dirty1", 128'(dirty_bit), 128'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
